mac_tx_buf: RTL and testbench



---
 rtl/eth_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/mac_tx_buf.sv | 232 +++++++++++++++++++++++
 tb/tb_mac_tx_buf.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet TX constants and the read-side FSM state
//                type used by mac_tx_buf.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

  localparam int MIN_PAYLOAD = 46;    // shorter payloads are zero-padded
  localparam int MAX_PAYLOAD = 1500;  // longer frames are discarded
  localparam int IFG_CYCLES  = 48;    // 96 bit times at 2 bits per clock

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with show-ahead read data. Holds the
//                lengths of committed frames for mac_tx_buf.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk, i_rst : clock, asynchronous active-high reset
//    i_push       : write i_data (ignored when full)
//    i_data       : entry to write
//    i_pop        : discard the head entry (ignored when empty)
//    o_data       : current head entry
//    o_full       : no free entry
//    o_empty      : no stored entry
//    o_count      : number of stored entries (0..2**DEPTH_LOG2)
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_buf
//  Description : Store-and-forward frame buffer in front of the RMII MAC
//                transmitter. Whole frames are written into a circular byte
//                RAM; each committed frame is replayed to the MAC as one
//                contiguous o_mac_valid burst, zero-padded to the minimum
//                payload, followed by the inter-frame gap.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk, i_rst  : 50 MHz RMII clock, asynchronous active-high reset
//    i_wr_valid    : application byte valid
//    i_wr_data     : application payload byte
//    i_wr_last     : final byte of the frame
//    o_wr_ready    : byte accepted when high with i_wr_valid
//    o_drop        : one-cycle pulse when an oversize frame is discarded
//    o_mac_valid   : frame in flight to the MAC
//    o_mac_data    : registered payload byte to the MAC
//    i_mac_req     : MAC request for the next byte
//    i_mac_busy    : MAC transmitting
//    o_pending     : committed frames not yet started
// ============================================================================
module mac_tx_buf
  import eth_pkg::*;
#(
  parameter int DEPTH_LOG2     = 11,
  parameter int LEN_DEPTH_LOG2 = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_valid,
  input  logic [7:0]              i_wr_data,
  input  logic                    i_wr_last,
  output logic                    o_wr_ready,
  output logic                    o_drop,
  output logic                    o_mac_valid,
  output logic [7:0]              o_mac_data,
  input  logic                    i_mac_req,
  input  logic                    i_mac_busy,
  output logic [LEN_DEPTH_LOG2:0] o_pending
);

  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [5:0]  IFG_LOAD = 6'(IFG_CYCLES);

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  logic [DEPTH_LOG2:0] wr_ptr_q,      wr_ptr_d;
  logic [DEPTH_LOG2:0] frame_start_q, frame_start_d;
  logic [10:0]         frame_len_q,   frame_len_d;
  logic                swallow_q,     swallow_d;
  logic                drop_q,        drop_d;

  // Read side
  rd_state_e           state_q,     state_d;
  logic [DEPTH_LOG2:0] rd_ptr_q,    rd_ptr_d;     // oldest byte still owned
  logic [DEPTH_LOG2:0] fetch_ptr_q, fetch_ptr_d;  // next byte to prefetch
  logic [10:0]         rem_q,       rem_d;
  logic [5:0]          pad_q,       pad_d;
  logic [5:0]          ifg_q,       ifg_d;
  logic                mac_valid_q, mac_valid_d;
  logic [7:0]          mac_data_q,  mac_data_d;
  logic [7:0]          ram_rdata_q;

  logic [7:0]          ram_q [0:(1 << DEPTH_LOG2) - 1];

  logic        w_full;
  logic        w_lenq_full;
  logic        w_lenq_empty;
  logic [10:0] w_len_head;
  logic        w_wr_ready;
  logic        w_wr_acc;
  logic        w_overflow;
  logic        w_ram_we;
  logic        w_commit;
  logic        w_pop;

  // Pointers carry one extra wrap bit: equal index with differing MSB = full.
  assign w_full = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // While swallowing a dropped frame nothing is stored, so space is irrelevant.
  assign w_wr_ready = ~i_rst & (swallow_q | (~w_full & ~w_lenq_full));
  assign w_wr_acc   = i_wr_valid & w_wr_ready;
  assign w_overflow = w_wr_acc & ~swallow_q & (frame_len_q == MAX_LEN);
  assign w_ram_we   = w_wr_acc & ~swallow_q & ~w_overflow;
  assign w_commit   = w_ram_we & i_wr_last;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    frame_len_d   = frame_len_q;
    swallow_d     = swallow_q;
    drop_d        = 1'b0;
    if (w_wr_acc) begin
      if (swallow_q) begin
        if (i_wr_last) swallow_d = 1'b0;
      end else if (w_overflow) begin
        wr_ptr_d    = frame_start_q;
        frame_len_d = '0;
        drop_d      = 1'b1;
        swallow_d   = ~i_wr_last;
      end else begin
        if (frame_len_q == '0) frame_start_d = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        frame_len_d = i_wr_last ? 11'd0 : frame_len_q + 11'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (11),
    .DEPTH_LOG2 (LEN_DEPTH_LOG2)
  ) u_len_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_commit),
    .i_data  (frame_len_q + 11'd1),
    .i_pop   (w_pop),
    .o_data  (w_len_head),
    .o_full  (w_lenq_full),
    .o_empty (w_lenq_empty),
    .o_count (o_pending)
  );

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    rem_d       = rem_q;
    pad_d       = pad_q;
    ifg_d       = ifg_q;
    mac_valid_d = mac_valid_q;
    mac_data_d  = mac_data_q;
    w_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // Keep the prefetch aimed at the next frame's first byte.
        fetch_ptr_d = rd_ptr_q;
        if (!w_lenq_empty && !i_mac_busy) begin
          w_pop       = 1'b1;
          rem_d       = w_len_head;
          pad_d       = (w_len_head < MIN_LEN) ? 6'(MIN_LEN - w_len_head) : 6'd0;
          mac_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (i_mac_req) begin
          if (rem_q != '0) begin
            mac_data_d  = ram_rdata_q;
            rem_d       = rem_q - 11'd1;
            fetch_ptr_d = fetch_ptr_q + 1'b1;
          end else if (pad_q != '0) begin
            mac_data_d = 8'h00;
            pad_d      = pad_q - 6'd1;
          end else begin
            // Frame fully delivered: give its RAM space back to the writer.
            mac_valid_d = 1'b0;
            rd_ptr_d    = fetch_ptr_q;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!i_mac_busy) begin
          ifg_d   = IFG_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (ifg_q == '0) state_d = IDLE;
        else             ifg_d   = ifg_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload RAM. The read is addressed by the next fetch pointer so the byte
  // for the following request is already in ram_rdata_q one cycle later.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      ram_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
    ram_rdata_q <= ram_q[fetch_ptr_d[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      frame_len_q   <= '0;
      swallow_q     <= 1'b0;
      drop_q        <= 1'b0;
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      fetch_ptr_q   <= '0;
      rem_q         <= '0;
      pad_q         <= '0;
      ifg_q         <= '0;
      mac_valid_q   <= 1'b0;
      mac_data_q    <= 8'h00;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      frame_len_q   <= frame_len_d;
      swallow_q     <= swallow_d;
      drop_q        <= drop_d;
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      fetch_ptr_q   <= fetch_ptr_d;
      rem_q         <= rem_d;
      pad_q         <= pad_d;
      ifg_q         <= ifg_d;
      mac_valid_q   <= mac_valid_d;
      mac_data_q    <= mac_data_d;
    end
  end

  assign o_wr_ready  = w_wr_ready;
  assign o_drop      = drop_q;
  assign o_mac_valid = mac_valid_q;
  assign o_mac_data  = mac_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_tx_buf
//  Description : Self-checking bench for mac_tx_buf. A driver writes frames
//                and queues the bytes the MAC must see; a MAC model issues
//                requests and pops/compares every delivered byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_buf;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_valid = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_wr_last = 1'b0;
  logic       i_mac_req = 1'b0;
  logic       i_mac_busy;
  logic       o_wr_ready;
  logic       o_drop;
  logic       o_mac_valid;
  logic [7:0] o_mac_data;
  logic [2:0] o_pending;

  always #10 i_clk = ~i_clk;

  mac_tx_buf #(
    .DEPTH_LOG2     (11),
    .LEN_DEPTH_LOG2 (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_valid  (i_wr_valid),
    .i_wr_data   (i_wr_data),
    .i_wr_last   (i_wr_last),
    .o_wr_ready  (o_wr_ready),
    .o_drop      (o_drop),
    .o_mac_valid (o_mac_valid),
    .o_mac_data  (o_mac_data),
    .i_mac_req   (i_mac_req),
    .i_mac_busy  (i_mac_busy),
    .o_pending   (o_pending)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames that must reach the MAC, as lengths and bytes.
  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_drops = 0;
  int         ready_low_seen = 0;

  // MAC model state
  bit busy_force = 1'b0;
  bit in_frame   = 1'b0;
  int nreq = 0, nbytes = 0, cnt = 0, period = 4;
  int low_cnt = 1000, tail = 0, frames_seen = 0, drops_seen = 0;

  assign i_mac_busy = busy_force | in_frame | (tail > 0);

  always @(negedge i_clk) begin
    bit ended;
    int len;
    ended = 1'b0;
    if (i_rst) begin
      in_frame  = 1'b0;
      i_mac_req = 1'b0;
      nreq = 0; cnt = 0; tail = 0; low_cnt = 1000;
    end else begin
      if (o_drop) drops_seen++;
      if (tail > 0) tail--;
      if (i_mac_req) begin
        i_mac_req = 1'b0;
        nreq++;
        if (nreq <= nbytes) begin
          if (exp_byte_q.size() == 0) check("mac_byte_unexpected", 1, 0);
          else                        check("mac_byte", o_mac_data, exp_byte_q.pop_front());
        end else begin
          check("valid_low_after_final_req", o_mac_valid, 0);
          in_frame = 1'b0;
          tail     = 3;
          ended    = 1'b1;
        end
      end else if (in_frame && !o_mac_valid) begin
        check("valid_dropped_early_reqs", nreq, nbytes + 1);
        in_frame = 1'b0;
        ended    = 1'b1;
      end
      if (!in_frame && o_mac_valid && !ended) begin
        if (frames_seen > 0) check("ifg_at_least_drain_plus_48", low_cnt >= 49, 1);
        frames_seen++;
        if (exp_len_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
          nbytes = 0;
        end else begin
          len    = exp_len_q.pop_front();
          nbytes = (len < 46) ? 46 : len;
        end
        in_frame = 1'b1;
        nreq = 0;
        cnt  = 0;
      end
      if (o_mac_valid) low_cnt = 0;
      else             low_cnt++;
      if (in_frame && !i_mac_req) begin
        cnt++;
        if (cnt >= period) begin
          i_mac_req = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // Writes one frame; called and returns at a negedge.
  task automatic send_frame(input int len);
    logic [7:0] data[$];
    int guard;
    for (int i = 0; i < len; i++) data.push_back(8'($urandom));
    if (len <= 1500) begin
      exp_len_q.push_back(len);
      foreach (data[k]) exp_byte_q.push_back(data[k]);
      for (int k = len; k < 46; k++) exp_byte_q.push_back(8'h00);
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < len; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = data[i];
      i_wr_last  = (i == len - 1);
      if (len > 1500 && i > 1500) check("ready_while_swallowing", o_wr_ready, 1);
      guard = 0;
      while (!o_wr_ready && guard < 20000) begin
        ready_low_seen++;
        @(negedge i_clk);
        guard++;
      end
      if (guard >= 20000) begin
        check("wr_ready_timeout", 0, 1);
        break;
      end
      @(negedge i_clk);
      if (len > 1500 && i == 1499) check("no_drop_at_1500", o_drop, 0);
      if (len > 1500 && i == 1500) check("drop_pulse_after_1501", o_drop, 1);
    end
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_len_q.size() != 0 || in_frame || o_mac_valid) && g < 30000) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 30000) check("drain_timeout", 0, 1);
    repeat (60) @(negedge i_clk);
  endtask

  initial begin
    int hi;
    int g;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_wr_ready", o_wr_ready, 0);
    check("rst_drop", o_drop, 0);
    check("rst_mac_valid", o_mac_valid, 0);
    check("rst_mac_data", o_mac_data, 0);
    check("rst_pending", o_pending, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("wr_ready_after_reset", o_wr_ready, 1);

    // 60-byte frame, request every 4 cycles
    period = 4;
    send_frame(60);
    check("pending_after_commit", o_pending, 1);
    @(negedge i_clk);
    check("pending_after_pop", o_pending, 0);
    wait_idle();

    // short frame padded with zeros
    send_frame(10);
    wait_idle();

    // oversize frame dropped, next frame intact
    send_frame(1510);
    check("pending_after_drop", o_pending, 0);
    send_frame(50);
    wait_idle();

    // MAC busy holds off the start
    busy_force = 1'b1;
    send_frame(30);
    hi = 0;
    repeat (100) begin
      @(negedge i_clk);
      if (o_mac_valid) hi++;
    end
    check("valid_held_while_busy", hi, 0);
    check("pending_while_busy", o_pending, 1);
    busy_force = 1'b0;
    wait_idle();

    // back-to-back 400-byte frames fill the RAM
    ready_low_seen = 0;
    repeat (7) send_frame(400);
    check("wr_ready_low_when_full", ready_low_seen > 0, 1);
    wait_idle();

    // randomized lengths, spacing and request rate
    repeat (10) begin
      period = $urandom_range(2, 5);
      send_frame($urandom_range(1, 300));
      repeat ($urandom_range(0, 20)) @(negedge i_clk);
    end
    wait_idle();

    // reset in the middle of a send
    period = 4;
    send_frame(100);
    send_frame(80);
    g = 0;
    while (!in_frame && g < 1000) begin
      @(negedge i_clk);
      g++;
    end
    check("in_frame_before_reset", in_frame, 1);
    check("pending_before_reset", o_pending, 1);
    i_rst = 1'b1;
    exp_len_q.delete();
    exp_byte_q.delete();
    #1;
    check("mid_send_rst_valid", o_mac_valid, 0);
    check("mid_send_rst_pending", o_pending, 0);
    check("mid_send_rst_ready", o_wr_ready, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_mid_reset", o_wr_ready, 1);
    send_frame(64);
    wait_idle();

    check("bytes_left_undelivered", exp_byte_q.size(), 0);
    check("frames_left_undelivered", exp_len_q.size(), 0);
    check("drop_pulse_count", drops_seen, exp_drops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
